// File: rtl/replicator_if.sv
// Bundles the nibble inputs and the four registered status outputs of the replicator.
// Ports: a,b,c,d  nibble bits (a = MSB); out1 parity, out2 majority, out3 serial replica, busy run flag.
// The master drives the nibble and observes outputs; the slave is the replicator side.
interface replicator_if;
    logic a;
    logic b;
    logic c;
    logic d;
    logic out1;
    logic out2;
    logic out3;
    logic busy;

    modport master (
        output a, b, c, d,
        input  out1, out2, out3, busy
    );

    modport slave (
        input  a, b, c, d,
        output out1, out2, out3, busy
    );
endinterface

// File: rtl/replicator.sv
// Purpose: registered parity/majority of a 4-bit nibble, plus a serial replay of the nibble
//          (MSB first, REPLICAS times back to back) started by any change of the nibble.
// Latency: out1/out2 one cycle after sampling; out3 bit a appears the cycle after the capture edge.
// Backpressure: none; while a run is in progress busy=1 and further changes are ignored, unless
//               REPLICATOR_RETRIGGER_EN is defined, in which case a change restarts the run.
// Ports: clk, rst_n (async active-low), bus (replicator_if.slave: a,b,c,d in; out1,out2,out3,busy out).
module replicator #(
    parameter int REPLICAS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    replicator_if.slave bus
);

`ifdef REPLICATOR_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    localparam logic [3:0] REP_LAST = 4'(REPLICAS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state, state_n;
    logic [3:0] nib;
    logic [3:0] prev;
    logic [3:0] cap, cap_n;
    logic [1:0] bit_cnt, bit_n;
    logic [3:0] rep_cnt, rep_n;
    logic       out3_n, busy_n;
    logic       change;
    logic       last_bit;

    assign nib      = {bus.a, bus.b, bus.c, bus.d};
    assign change   = (nib != prev);
    // bit_cnt/rep_cnt name the bit currently on out3, so the run ends after this one.
    assign last_bit = (bit_cnt == 2'd3) && (rep_cnt == REP_LAST);

    // Parity, majority and the change-detect history run every cycle regardless of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out1 <= 1'b0;
            bus.out2 <= 1'b0;
            prev     <= 4'b0000;
        end else begin
            bus.out1 <= ^nib;
            bus.out2 <= ($countones(nib) >= 3);
            prev     <= nib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cap      <= 4'b0000;
            bit_cnt  <= 2'd0;
            rep_cnt  <= 4'd0;
            bus.out3 <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state    <= state_n;
            cap      <= cap_n;
            bit_cnt  <= bit_n;
            rep_cnt  <= rep_n;
            bus.out3 <= out3_n;
            bus.busy <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cap_n   = cap;
        bit_n   = bit_cnt;
        rep_n   = rep_cnt;
        out3_n  = 1'b0;
        busy_n  = 1'b0;
        case (state)
            IDLE: begin
                if (change) begin
                    state_n = SHIFT;
                    cap_n   = nib;
                    bit_n   = 2'd0;
                    rep_n   = 4'd0;
                    out3_n  = nib[3];
                    busy_n  = 1'b1;
                end
            end
            SHIFT: begin
                if (RETRIG && change) begin
                    cap_n  = nib;
                    bit_n  = 2'd0;
                    rep_n  = 4'd0;
                    out3_n = nib[3];
                    busy_n = 1'b1;
                end else if (last_bit) begin
                    state_n = IDLE;
                end else begin
                    busy_n = 1'b1;
                    if (bit_cnt == 2'd3) begin
                        bit_n = 2'd0;
                        rep_n = rep_cnt + 4'd1;
                    end else begin
                        bit_n = bit_cnt + 2'd1;
                    end
                    // Bit index 3-bit_n: a first, d last.
                    out3_n = cap[~bit_n];
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_replicator.sv
module tb_replicator;
    localparam int R = 2;

`ifdef REPLICATOR_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    replicator_if bus ();

    replicator #(.REPLICAS(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of bits still to appear on out3, head = bit visible now.
    logic [3:0] m_prev;
    logic [3:0] m_nib;
    logic       m_chg, m_was;
    bit         q[$];
    logic       e1, e2, e3, eb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 4'b0000;
            q.delete();
            e1 = 1'b0; e2 = 1'b0; e3 = 1'b0; eb = 1'b0;
        end else begin
            m_nib  = {bus.a, bus.b, bus.c, bus.d};
            m_chg  = (m_nib != m_prev);
            m_prev = m_nib;
            m_was  = (q.size() > 0);
            if (m_was) void'(q.pop_front());
            if (m_chg && (!m_was || RETRIG)) begin
                q.delete();
                for (int r = 0; r < R; r++)
                    for (int i = 0; i < 4; i++)
                        q.push_back(m_nib[2'(3 - i)]);
            end
            e1 = ^m_nib;
            e2 = ($countones(m_nib) >= 3);
            e3 = (q.size() > 0) ? q[0] : 1'b0;
            eb = (q.size() > 0);
        end
    end

    always @(negedge clk) begin
        check("out1", bus.out1, e1);
        check("out2", bus.out2, e2);
        check("out3", bus.out3, e3);
        check("busy", bus.busy, eb);
    end

    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        #1 {bus.a, bus.b, bus.c, bus.d} = v;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (bus.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", bus.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        int          bcnt;
        {bus.a, bus.b, bus.c, bus.d} = 4'b0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out1", bus.out1, 1'b0);
        check("rst_out3", bus.out3, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", bus.busy, 1'b0);

        // Single 1010 run: 8 bits, busy for exactly 8 cycles
        drive(4'b1010);
        seq = '0; bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seq = {seq[14:0], bus.out3};
            bcnt += int'(bus.busy);
        end
        check("run1010_seq", seq, 16'b10101010);
        check("run1010_busy", 16'(bcnt), 16'd8);
        @(negedge clk);
        check("run1010_end_out3", bus.out3, 1'b0);
        check("run1010_end_busy", bus.busy, 1'b0);

        // Change to 0101 during the third bit cycle
        drive(4'b0000);
        wait_idle();
        drive(4'b1010);
        seq = '0; bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seq = {seq[14:0], bus.out3};
            bcnt += int'(bus.busy);
            if (i == 2) #1 {bus.a, bus.b, bus.c, bus.d} = 4'b0101;
        end
        if (RETRIG) begin
            check("retrig_seq", seq, 16'b101010101010);
            check("retrig_busy", 16'(bcnt), 16'd11);
        end else begin
            check("noretrig_seq", seq, 16'b101010100000);
            check("noretrig_busy", 16'(bcnt), 16'd8);
        end
        bcnt = 0;
        repeat (10) begin
            @(negedge clk);
            bcnt += int'(bus.busy);
        end
        check("no_second_run", 16'(bcnt), 16'd0);

        // Stable 1100: exactly one 8-bit run
        drive(4'b1100);
        bcnt = 0;
        repeat (28) begin
            @(negedge clk);
            bcnt += int'(bus.busy);
        end
        check("stable1100_busy", 16'(bcnt), 16'd8);

        // Sweep 0000..1111, 5 cycles each
        for (int v = 0; v < 16; v++) begin
            drive(4'(v));
            @(negedge clk);
            if (v == 7) begin
                check("sweep0111_out1", bus.out1, 1'b1);
                check("sweep0111_out2", bus.out2, 1'b1);
            end
            if (v == 3) begin
                check("sweep0011_out1", bus.out1, 1'b0);
                check("sweep0011_out2", bus.out2, 1'b0);
            end
            repeat (3) @(negedge clk);
        end

        // Asynchronous reset mid-run with 1111 applied
        drive(4'b0000);
        wait_idle();
        drive(4'b1111);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out1", bus.out1, 1'b0);
        check("async_out2", bus.out2, 1'b0);
        check("async_out3", bus.out3, 1'b0);
        check("async_busy", bus.busy, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        // First edge after release sees 1111 against prev=0000
        @(negedge clk);
        check("post_rst_busy", bus.busy, 1'b1);
        check("post_rst_out3", bus.out3, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/replicator.md
REPLICATOR -- requirements
Module: replicator

Interface
REQ-001 Parameter REPLICAS, default 2, number of times the captured nibble is replayed on out3 per run; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a  input  1  nibble bit 3 (MSB), synchronous to clk.
REQ-005 b  input  1  nibble bit 2.
REQ-006 c  input  1  nibble bit 1.
REQ-007 d  input  1  nibble bit 0 (LSB).
REQ-008 out1  output  1  registered odd parity of {a,b,c,d}.
REQ-009 out2  output  1  registered majority flag, 1 when three or more of a,b,c,d are 1.
REQ-010 out3  output  1  registered serial replica stream of the captured nibble.
REQ-011 busy  output  1  registered; 1 while a replica run is in progress.

Function
REQ-012 out1 = a^b^c^d sampled at edge N, visible after edge N; latency 1 cycle, updated every cycle.
REQ-013 out2 = (popcount({a,b,c,d}) >= 3), latency 1 cycle, updated every cycle.
REQ-014 Register prev holds {a,b,c,d} from the previous edge and is updated every cycle, busy or not.
REQ-015 Change event: {a,b,c,d} != prev at a rising edge.
REQ-016 FSM states: IDLE, SHIFT.
REQ-017 IDLE: out3=0, busy=0. On a change event, capture the nibble, clear the bit and replica counters, and enter SHIFT.
REQ-018 SHIFT: out3 presents captured bits MSB first (a,b,c,d), one bit per cycle, starting the cycle after the capture edge.
REQ-019 SHIFT: busy=1. After bit d of replica k, replica k+1 starts with bit a on the next cycle, with no gap.
REQ-020 After 4*REPLICAS bits, return to IDLE; out3=0 and busy=0 on the following cycle.
REQ-021 Change events during SHIFT, including on the final bit, are discarded: no queueing and no deferred run (macro absent).
REQ-022 Captured nibble is frozen for the whole run; input changes do not alter out3 mid-run.
REQ-023 Replica counter width is 4 bits and the bit counter width is 2 bits; counters must not wrap beyond REPLICAS.

Reset
REQ-024 While rst_n=0: out1, out2, out3 and busy are 0, prev=0000, the captured nibble is 0000, the counters are 0, and the state is IDLE, all asynchronously.
REQ-025 Reset mid-run aborts the run immediately; out3 drops to 0 without waiting for clk.
REQ-026 After reset release, a nonzero input nibble at the first edge is a change event (against prev=0000) and starts a run.

Configuration
REQ-027 Macro REPLICATOR_RETRIGGER_EN defined: a change event during SHIFT, including on the last bit, recaptures the new nibble, resets both counters and restarts the run, with the new nibble's bit a appearing the next cycle.
REQ-028 Macro REPLICATOR_RETRIGGER_EN undefined: REQ-021 applies.
REQ-029 out1, out2 and the reset behaviour are identical in both builds.

Verification (REPLICAS=2)
REQ-030 Drive rst_n=0 with abcd=1111 mid-run -> out1=out2=out3=busy=0 before the next clk edge.
REQ-031 Sweep abcd 0000..1111, holding each for 5 cycles -> out1/out2 match parity/majority one cycle after each change (e.g. 0111 -> out1=1, out2=1; 0011 -> out1=0, out2=0).
REQ-032 Idle with 0000, then 1010 -> out3 = 1,0,1,0,1,0,1,0 on the next 8 cycles, busy=1 for exactly those 8, then out3=0 and busy=0.
REQ-033 Macro undefined: 1010 run, then 0101 applied on the 3rd bit cycle -> out3 sequence unchanged and no second run afterwards.
REQ-034 Macro defined: same stimulus as REQ-033 -> out3 = 1,0,1 then 0,1,0,1,0,1,0,1, with busy continuous.
REQ-035 Hold 1100 stable for 20 cycles after its run ends -> exactly one run of 8 bits.
